sad_accum: RTL and testbench

//  Streaming sum-of-absolute-differences (SAD) unit.
//  - Successor to the 4-bit combinational |a-b| block: parametrised width, optional signed mode, pipelined, accumulates over a block.
//  - Accepts one (a,b) sample pair per cycle under valid/ready.
//  - Emits the SAD over every LEN accepted pairs under valid/ready.
//  - Sits between sample sources (counters/registers) and display/compare logic.

---
 rtl/sad_accum_pkg.sv | 19 +
 rtl/sad_accum_if.sv | 30 +++
 rtl/sad_accum_abs_diff_n.sv | 30 +++
 rtl/sad_accum.sv | 103 ++++++++++
 tb/tb_sad_accum.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/sad_accum_pkg.sv
// Shared types and width helpers for the streaming SAD unit.
package sad_accum_pkg;

  // RUN: taking samples; HOLD: a block result is waiting for the consumer.
  typedef enum logic {
    RUN  = 1'b0,
    HOLD = 1'b1
  } sad_state_e;

  // The widest possible sum is len * (2^n - 1), which always fits in n + clog2(len) bits.
  function automatic int acc_width(input int n, input int len);
    return n + $clog2(len);
  endfunction

  function automatic int cnt_width(input int len);
    return $clog2(len);
  endfunction

endpackage

// File: rtl/sad_accum_if.sv
// Sample intake and block-result handshake bundle for sad_accum.
interface sad_accum_if
  import sad_accum_pkg::*;
#(
  parameter int N   = 4,
  parameter int LEN = 8
);
  localparam int ACC_W = acc_width(N, LEN);
  localparam int CNT_W = cnt_width(LEN);

  logic             in_valid;
  logic             in_ready;
  logic [N-1:0]     a_in;
  logic [N-1:0]     b_in;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] sad_out;
  logic [CNT_W-1:0] cnt_out;

  modport master (
    output in_valid, a_in, b_in, out_ready,
    input  in_ready, out_valid, sad_out, cnt_out
  );

  modport slave (
    input  in_valid, a_in, b_in, out_ready,
    output in_ready, out_valid, sad_out, cnt_out
  );

endinterface

// File: rtl/sad_accum_abs_diff_n.sv
// Combinational |a-b| returned as an N-bit unsigned magnitude.
// Compares as signed or unsigned per SIGNED, then subtracts smaller from larger.
module abs_diff_n #(
  parameter int N      = 4,
  parameter bit SIGNED = 1'b0
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] diff
);

  logic         a_lt_b;
  logic [N-1:0] larger;
  logic [N-1:0] smaller;

  always_comb begin
    if (SIGNED) begin
      a_lt_b = $signed(a) < $signed(b);
    end else begin
      a_lt_b = a < b;
    end
  end

  assign larger  = a_lt_b ? b : a;
  assign smaller = a_lt_b ? a : b;

  // Modulo-2^N subtraction is exact here: the true difference is at most 2^N-1 in either mode.
  assign diff = larger + ~smaller + N'(1);

endmodule

// File: rtl/sad_accum.sv
// Streaming SAD over LEN accepted (a,b) pairs; result is registered one edge after the last pair's stage-1 edge.
// Intake stalls for one bubble after each block's last sample and while a result is unconsumed.
module sad_accum
  import sad_accum_pkg::*;
#(
  parameter int N      = 4,
  parameter int LEN    = 8,
  parameter bit SIGNED = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  sad_accum_if.slave  bus
);

  localparam int ACC_W = acc_width(N, LEN);
  localparam int CNT_W = cnt_width(LEN);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LEN - 1);

  sad_state_e       state_q;
  sad_state_e       state_d;
  logic [N-1:0]     d_abs;
  logic [N-1:0]     d1;
  logic             v1;
  logic             last1;
  logic [CNT_W-1:0] cnt;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] sad_q;
  logic             accept;
  logic             block_done;

  abs_diff_n #(
    .N      (N),
    .SIGNED (SIGNED)
  ) u_abs (
    .a    (bus.a_in),
    .b    (bus.b_in),
    .diff (d_abs)
  );

  assign block_done   = v1 && last1;
  assign bus.in_ready = (state_q == RUN) && !block_done;
  assign accept       = bus.in_valid && bus.in_ready;

  // Stage 1: register the magnitude and tag the block's final sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      d1    <= '0;
      v1    <= 1'b0;
      last1 <= 1'b0;
    end else begin
      v1    <= accept;
      last1 <= accept && (cnt == CNT_LAST);
      if (accept) begin
        d1 <= d_abs;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (accept) begin
      cnt <= (cnt == CNT_LAST) ? '0 : cnt + CNT_W'(1);
    end
  end

  // Stage 2: the last sample folds straight into the result so acc restarts clean.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc   <= '0;
      sad_q <= '0;
    end else if (v1) begin
      if (last1) begin
        sad_q <= acc + ACC_W'(d1);
        acc   <= '0;
      end else begin
        acc   <= acc + ACC_W'(d1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (block_done)    state_d = HOLD;
      HOLD:    if (bus.out_ready) state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  assign bus.out_valid = (state_q == HOLD);
  assign bus.sad_out   = sad_q;
  assign bus.cnt_out   = cnt;

endmodule

// File: tb/tb_sad_accum.sv
// Directed plus randomized checks of sad_accum in unsigned and signed modes (N=4, LEN=4).
module tb_sad_accum;

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  sad_accum_if #(.N(4), .LEN(4)) bu ();
  sad_accum_if #(.N(4), .LEN(4)) bs ();

  sad_accum #(.N(4), .LEN(4), .SIGNED(1'b0)) u_uns (.clk(clk), .rst(rst), .bus(bu));
  sad_accum #(.N(4), .LEN(4), .SIGNED(1'b1)) u_sgn (.clk(clk), .rst(rst), .bus(bs));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int udiff(input logic [3:0] a, input logic [3:0] b);
    int x = int'(a);
    int y = int'(b);
    return (x > y) ? x - y : y - x;
  endfunction

  function automatic int sx(input logic [3:0] v);
    return v[3] ? int'(v) - 16 : int'(v);
  endfunction

  function automatic int sdiff(input logic [3:0] a, input logic [3:0] b);
    int x = sx(a);
    int y = sx(b);
    return (x > y) ? x - y : y - x;
  endfunction

  // Offer one pair and hold it until taken; returns at the cycle after the accepting edge.
  task automatic push_u(input logic [3:0] a, input logic [3:0] b);
    int g = 0;
    bu.in_valid = 1'b1;
    bu.a_in     = a;
    bu.b_in     = b;
    while (bu.in_ready !== 1'b1 && g < 100) begin
      tick();
      g++;
    end
    chk("push_u_timeout", 32'(g < 100), 32'd1);
    tick();
    bu.in_valid = 1'b0;
  endtask

  task automatic push_s(input logic [3:0] a, input logic [3:0] b);
    int g = 0;
    bs.in_valid = 1'b1;
    bs.a_in     = a;
    bs.b_in     = b;
    while (bs.in_ready !== 1'b1 && g < 100) begin
      tick();
      g++;
    end
    chk("push_s_timeout", 32'(g < 100), 32'd1);
    tick();
    bs.in_valid = 1'b0;
  endtask

  task automatic wait_out_u();
    int g = 0;
    while (bu.out_valid !== 1'b1 && g < 100) begin
      tick();
      g++;
    end
    chk("wait_u_timeout", 32'(g < 100), 32'd1);
  endtask

  task automatic wait_out_s();
    int g = 0;
    while (bs.out_valid !== 1'b1 && g < 100) begin
      tick();
      g++;
    end
    chk("wait_s_timeout", 32'(g < 100), 32'd1);
  endtask

  initial begin
    logic [3:0] pa [4];
    logic [3:0] pb [4];
    logic [3:0] ta [7];
    logic [3:0] tb [7];
    bit         tv [7];
    int         sum;
    int         exp_cnt;
    int         hold;
    logic [5:0] held;

    rst = 1'b1;
    bu.in_valid = 1'b0; bu.a_in = '0; bu.b_in = '0; bu.out_ready = 1'b1;
    bs.in_valid = 1'b0; bs.a_in = '0; bs.b_in = '0; bs.out_ready = 1'b1;

    // Reset held for two edges.
    tick();
    tick();
    rst = 1'b0;
    chk("rst_out_valid", 32'(bu.out_valid), 32'd0);
    chk("rst_sad_out",   32'(bu.sad_out),   32'd0);
    chk("rst_cnt_out",   32'(bu.cnt_out),   32'd0);
    chk("rst_in_ready",  32'(bu.in_ready),  32'd1);
    chk("rst_s_valid",   32'(bs.out_valid), 32'd0);
    chk("rst_s_ready",   32'(bs.in_ready),  32'd1);

    // Streaming block, consumer always ready.
    pa = '{4'd3, 4'd9, 4'd15, 4'd0};
    pb = '{4'd9, 4'd3, 4'd0,  4'd0};
    sum = 0;
    for (int i = 0; i < 4; i++) begin
      push_u(pa[i], pb[i]);
      sum += udiff(pa[i], pb[i]);
      chk("stream_cnt", 32'(bu.cnt_out), 32'((i + 1) % 4));
    end
    chk("stream_ref_sum",     32'(sum),          32'd27);
    chk("stream_valid_early", 32'(bu.out_valid), 32'd0);
    chk("stream_bubble",      32'(bu.in_ready),  32'd0);
    tick();
    chk("stream_valid", 32'(bu.out_valid), 32'd1);
    chk("stream_sad",   32'(bu.sad_out),   32'(sum));
    chk("stream_ready_pending", 32'(bu.in_ready), 32'd0);
    tick();
    chk("stream_valid_clr", 32'(bu.out_valid), 32'd0);
    chk("stream_resume",    32'(bu.in_ready),  32'd1);
    chk("stream_sad_hold",  32'(bu.sad_out),   32'd27);

    // Second block immediately after.
    sum = 0;
    for (int i = 0; i < 4; i++) begin
      pa[i] = 4'($urandom_range(0, 15));
      pb[i] = 4'($urandom_range(0, 15));
      push_u(pa[i], pb[i]);
      sum += udiff(pa[i], pb[i]);
    end
    wait_out_u();
    chk("block2_sad", 32'(bu.sad_out), 32'(sum));
    tick();
    chk("block2_clr", 32'(bu.out_valid), 32'd0);

    // Backpressure: result must stay put and no sample may enter.
    bu.out_ready = 1'b0;
    pa = '{4'd3, 4'd9, 4'd15, 4'd0};
    pb = '{4'd9, 4'd3, 4'd0,  4'd0};
    for (int i = 0; i < 4; i++) push_u(pa[i], pb[i]);
    wait_out_u();
    chk("bp_sad", 32'(bu.sad_out), 32'd27);
    bu.in_valid = 1'b1; bu.a_in = 4'd5; bu.b_in = 4'd1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_valid_stable", 32'(bu.out_valid), 32'd1);
      chk("bp_sad_stable",   32'(bu.sad_out),   32'd27);
      chk("bp_in_ready",     32'(bu.in_ready),  32'd0);
      chk("bp_cnt",          32'(bu.cnt_out),   32'd0);
    end
    bu.in_valid  = 1'b0;
    bu.out_ready = 1'b1;
    chk("bp_ready_same_cycle", 32'(bu.in_ready), 32'd0);
    tick();
    chk("bp_release_valid", 32'(bu.out_valid), 32'd0);
    chk("bp_release_ready", 32'(bu.in_ready),  32'd1);

    // in_valid gaps must not advance the count or the sum.
    tv = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    ta = '{4'd1, 4'd7, 4'd7, 4'd4, 4'd7, 4'd5, 4'd0};
    tb = '{4'd2, 4'd0, 4'd0, 4'd0, 4'd0, 4'd5, 4'd15};
    exp_cnt = 0;
    sum = 0;
    for (int i = 0; i < 7; i++) begin
      bu.in_valid = tv[i];
      bu.a_in     = ta[i];
      bu.b_in     = tb[i];
      chk("gap_in_ready", 32'(bu.in_ready), 32'd1);
      tick();
      if (tv[i]) begin
        exp_cnt = (exp_cnt + 1) % 4;
        sum += udiff(ta[i], tb[i]);
      end
      chk("gap_cnt", 32'(bu.cnt_out), 32'(exp_cnt));
    end
    bu.in_valid = 1'b0;
    tick();
    chk("gap_valid", 32'(bu.out_valid), 32'd1);
    chk("gap_sad",   32'(bu.sad_out),   32'(sum));
    chk("gap_sad20", 32'(sum),          32'd20);
    tick();

    // Reset mid-block discards the partial sum.
    push_u(4'd9, 4'd0);
    push_u(4'd9, 4'd0);
    chk("midrst_cnt_before", 32'(bu.cnt_out), 32'd2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_cnt",   32'(bu.cnt_out),  32'd0);
    chk("midrst_ready", 32'(bu.in_ready), 32'd1);
    for (int i = 0; i < 4; i++) push_u(4'd1, 4'd0);
    wait_out_u();
    chk("midrst_sad", 32'(bu.sad_out), 32'd4);
    tick();

    // Signed mode, extreme operands.
    pa = '{4'h8, 4'h7, 4'hF, 4'h0};
    pb = '{4'h7, 4'h8, 4'h1, 4'h0};
    sum = 0;
    for (int i = 0; i < 4; i++) begin
      push_s(pa[i], pb[i]);
      sum += sdiff(pa[i], pb[i]);
    end
    wait_out_s();
    chk("signed_sad",   32'(bs.sad_out), 32'd32);
    chk("signed_model", 32'(bs.sad_out), 32'(sum));
    tick();

    // Random unsigned blocks with idle gaps and random consumer stalls.
    for (int blk = 0; blk < 16; blk++) begin
      sum = 0;
      for (int i = 0; i < 4; i++) begin
        repeat ($urandom_range(0, 2)) tick();
        pa[i] = 4'($urandom_range(0, 15));
        pb[i] = 4'($urandom_range(0, 15));
        push_u(pa[i], pb[i]);
        sum += udiff(pa[i], pb[i]);
        chk("rnd_cnt", 32'(bu.cnt_out), 32'((i + 1) % 4));
      end
      bu.out_ready = 1'($urandom_range(0, 1));
      wait_out_u();
      chk("rnd_sad", 32'(bu.sad_out), 32'(sum));
      held = bu.sad_out;
      if (bu.out_ready == 1'b0) begin
        hold = $urandom_range(1, 4);
        for (int k = 0; k < hold; k++) begin
          tick();
          chk("rnd_hold_valid", 32'(bu.out_valid), 32'd1);
          chk("rnd_hold_sad",   32'(bu.sad_out),   32'(held));
        end
        bu.out_ready = 1'b1;
      end
      tick();
      chk("rnd_clr", 32'(bu.out_valid), 32'd0);
    end

    // Random signed blocks.
    for (int blk = 0; blk < 8; blk++) begin
      sum = 0;
      for (int i = 0; i < 4; i++) begin
        pa[i] = 4'($urandom_range(0, 15));
        pb[i] = 4'($urandom_range(0, 15));
        push_s(pa[i], pb[i]);
        sum += sdiff(pa[i], pb[i]);
      end
      wait_out_s();
      chk("rnd_signed_sad", 32'(bs.sad_out), 32'(sum));
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
